// File: rtl/logic_unit_pkg.sv
// Shared opcode definitions for the registered logic unit.
package logic_unit_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_NAND = OP_W'(3);
  localparam logic [OP_W-1:0] OP_NOR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XNOR = OP_W'(5);
  localparam logic [OP_W-1:0] OP_NOT  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BUF  = OP_W'(7);

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise gate array plus result flags.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ones,
  output logic             parity
);

  always_comb begin
    result = a;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_NOT:  result = ~a;
      default: result = a;
    endcase
  end

  assign zero   = (result == '0);
  assign ones   = &result;
  assign parity = ^result;

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit with valid/ready handshake, accumulator and
// saturating transaction counter.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [OP_W-1:0]    in_op,
  input  logic               acc_en,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero,
  output logic               out_ones,
  output logic               out_parity,
  output logic [WIDTH-1:0]   acc_q,
  output logic [COUNT_W-1:0] txn_count
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_ones;
  logic             core_parity;

  // Stage is free when empty or being drained this cycle.
  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign b_eff    = acc_en ? acc_q : in_b;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .op     (in_op),
    .a      (in_a),
    .b      (b_eff),
    .result (core_result),
    .zero   (core_zero),
    .ones   (core_ones),
    .parity (core_parity)
  );

  // Output register stage; data and flags only move on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_zero   <= 1'b0;
      out_ones   <= 1'b0;
      out_parity <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_data   <= core_result;
      out_zero   <= core_zero;
      out_ones   <= core_ones;
      out_parity <= core_parity;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Clear wins over an accumulate update landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (acc_clr) begin
      acc_q <= '0;
    end else if (accept && acc_en) begin
      acc_q <= core_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txn_count <= '0;
    end else if (accept && (txn_count != CNT_MAX)) begin
      txn_count <= txn_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (WIDTH=8, COUNT_W=4).
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       acc_en;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_zero;
  logic       out_ones;
  logic       out_parity;
  logic [7:0] acc_q;
  logic [3:0] txn_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sweep_exp [8];

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .COUNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .acc_en     (acc_en),
    .acc_clr    (acc_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_zero   (out_zero),
    .out_ones   (out_ones),
    .out_parity (out_parity),
    .acc_q      (acc_q),
    .txn_count  (txn_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sweep_exp[0] = 8'h30; sweep_exp[1] = 8'hFC; sweep_exp[2] = 8'hCC; sweep_exp[3] = 8'hCF;
    sweep_exp[4] = 8'h03; sweep_exp[5] = 8'h33; sweep_exp[6] = 8'h0F; sweep_exp[7] = 8'hF0;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_acc_q", 32'(acc_q), 32'h0);
    check("rst_txn", 32'(txn_count), 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'h1);

    // Opcode sweep, back-to-back
    in_valid = 1'b1; in_a = 8'hF0; in_b = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      in_op = 3'(i);
      tick();
      check($sformatf("sweep_data_op%0d", i), 32'(out_data), 32'(sweep_exp[i]));
      check($sformatf("sweep_valid_op%0d", i), 32'(out_valid), 32'h1);
    end
    check("sweep_txn", 32'(txn_count), 32'h8);

    // Backpressure
    in_op = 3'd0;
    tick();
    check("bp_first", 32'(out_data), 32'h30);
    out_ready = 1'b0; in_a = 8'hFF; in_op = 3'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'h0);
      tick();
      check($sformatf("bp_hold_%0d", i), 32'(out_data), 32'h30);
      check($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'h1);
    tick();
    check("bp_ff_data", 32'(out_data), 32'hFF);
    check("bp_ff_ones", 32'(out_ones), 32'h1);
    check("bp_ff_parity", 32'(out_parity), 32'h0);
    check("bp_txn", 32'(txn_count), 32'hA);
    in_valid = 1'b0;
    tick();
    check("drain_valid", 32'(out_valid), 32'h0);
    check("drain_data", 32'(out_data), 32'hFF);

    // Idle with undriven opcode must not disturb state
    in_op = 3'bx;
    tick();
    check("idle_x_data", 32'(out_data), 32'hFF);
    check("idle_x_txn", 32'(txn_count), 32'hA);

    // Accumulate XOR
    acc_clr = 1'b1;
    tick();
    check("acc_clr", 32'(acc_q), 32'h0);
    acc_clr = 1'b0; acc_en = 1'b1; in_op = 3'd2; in_b = 8'hFF; in_valid = 1'b1;
    in_a = 8'h01;
    tick();
    check("acc_1", 32'(out_data), 32'h01);
    in_a = 8'h02;
    tick();
    check("acc_2", 32'(out_data), 32'h03);
    in_a = 8'h04;
    tick();
    check("acc_3", 32'(out_data), 32'h07);
    check("acc_3_q", 32'(acc_q), 32'h07);
    check("acc_3_parity", 32'(out_parity), 32'h1);

    // Clear colliding with accumulate: op uses old acc, clear wins
    in_a = 8'h08; acc_clr = 1'b1;
    tick();
    check("coll_data", 32'(out_data), 32'h0F);
    check("coll_acc", 32'(acc_q), 32'h00);
    check("coll_txn", 32'(txn_count), 32'hE);
    acc_clr = 1'b0; acc_en = 1'b0;

    // Flags and counter saturation
    in_a = 8'hAA; in_b = 8'hAA; in_op = 3'd2;
    tick();
    check("flag_zero", 32'(out_zero), 32'h1);
    check("flag_parity", 32'(out_parity), 32'h0);
    check("flag_ones", 32'(out_ones), 32'h0);
    check("flag_txn", 32'(txn_count), 32'hF);
    in_op = 3'd7;
    for (int i = 0; i < 20; i++) begin
      in_a = 8'(i + 1);
      tick();
    end
    check("sat_txn", 32'(txn_count), 32'hF);
    check("sat_last_data", 32'(out_data), 32'h14);

    // Reset mid-stall
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b1; in_op = 3'd7; in_a = 8'h55; acc_en = 1'b1;
    tick();
    acc_en = 1'b0; in_a = 8'h11;
    tick();
    in_a = 8'h22;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    check("stall_valid", 32'(out_valid), 32'h1);
    check("stall_acc", 32'(acc_q), 32'h55);
    check("stall_txn", 32'(txn_count), 32'h3);
    check("stall_data", 32'(out_data), 32'h22);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    check("mrst_valid", 32'(out_valid), 32'h0);
    check("mrst_data", 32'(out_data), 32'h0);
    check("mrst_acc", 32'(acc_q), 32'h0);
    check("mrst_txn", 32'(txn_count), 32'h0);
    check("mrst_zero_flag", 32'(out_zero), 32'h0);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    check("mrst_after_ready", 32'(in_ready), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
